// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler for the 4x4 FIFO switch: pops one input FIFO head per cycle,
// pushes it to the output FIFO named by the word's top two bits, and owns the FIFO thresholds.
module fifo_rr_scheduler #(
    parameter int DATA_W   = 10,
    parameter int N        = 4,
    parameter int LIM_W    = 3,
    parameter int LOW_RST  = 1,
    parameter int HIGH_RST = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [LIM_W-1:0]    limit_low_in,
    input  logic [LIM_W-1:0]    limit_high_in,
    input  logic [N-1:0]        in_empty,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [N-1:0]        out_afull,
    output logic [N-1:0]        pop,
    output logic [N-1:0]        push,
    output logic [DATA_W-1:0]   data_out,
    output logic [LIM_W-1:0]    limit_low,
    output logic [LIM_W-1:0]    limit_high,
    output logic [1:0]          state,
    output logic                idle,
    output logic [7:0]          xfer_cnt
);

    // Handshake: pop[g] and push[dest] are single-cycle strobes issued together;
    // the input FIFO consumes its head on the pop edge, the output FIFO writes
    // data_out on the push edge. There is no ready; out_afull is the only backpressure.

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    logic [1:0]        state_next;
    logic [1:0]        rr;
    logic [N-1:0]      mask;
    logic [N-1:0]      elig;
    logic [1:0]        dest [N];
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [DATA_W-1:0] grant_word;
    logic [1:0]        grant_dest;
    logic [N-1:0]      grant_oh;
    logic [N-1:0]      dest_oh;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dest[i] = in_data[i*DATA_W+DATA_W-2 +: 2];
            elig[i] = (state == ST_ACTIVE) && !in_empty[i] && !out_afull[dest[i]] && !mask[i];
        end
    end

    // Scan from the farthest offset down so the nearest eligible index after rr wins.
    always_comb begin
        logic [1:0] idx;
        idx         = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N-1; k >= 0; k--) begin
            idx = rr + 2'(k);
            if (elig[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        grant_word = in_data[int'(grant_idx)*DATA_W +: DATA_W];
        grant_dest = grant_word[DATA_W-1 -: 2];
        grant_oh   = N'(1) << grant_idx;
        dest_oh    = N'(1) << grant_dest;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RESET;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT:   state_next = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init)           state_next = ST_INIT;
                else if (~&in_empty) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                       state_next = ST_INIT;
                else if (&in_empty && push == '0 && pop == '0) state_next = ST_IDLE;
            end
            default:   state_next = ST_RESET;
        endcase
    end

    always_comb begin
        idle = (state == ST_IDLE) && (push == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop        <= '0;
            push       <= '0;
            mask       <= '0;
            rr         <= '0;
            data_out   <= '0;
            xfer_cnt   <= '0;
            limit_low  <= LIM_W'(LOW_RST);
            limit_high <= LIM_W'(HIGH_RST);
        end else begin
            pop  <= grant_valid ? grant_oh : '0;
            push <= grant_valid ? dest_oh  : '0;
            // The popped FIFO's flags are stale for one cycle, so it sits out the next grant.
            mask <= grant_valid ? grant_oh : '0;
            if (grant_valid) begin
                data_out <= grant_word;
                rr       <= grant_idx + 2'd1;
                xfer_cnt <= xfer_cnt + 8'd1;
            end
            if (state == ST_INIT && limit_low_in < limit_high_in) begin
                limit_low  <= limit_low_in;
                limit_high <= limit_high_in;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Randomized bench for fifo_rr_scheduler: behavioural input FIFOs, a cycle model of the
// scheduling rules, and a scoreboard of expected pop/push/data strobes.
module tb_fifo_rr_scheduler;
  localparam int W  = 10;
  localparam int N  = 4;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            init = 1'b0;
  logic [LW-1:0]   limit_low_in = '0;
  logic [LW-1:0]   limit_high_in = '0;
  logic [N-1:0]    in_empty = '1;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    out_afull = '0;
  logic [N-1:0]    pop;
  logic [N-1:0]    push;
  logic [W-1:0]    data_out;
  logic [LW-1:0]   limit_low;
  logic [LW-1:0]   limit_high;
  logic [1:0]      state;
  logic            idle;
  logic [7:0]      xfer_cnt;

  int total = 0;
  int bad = 0;

  fifo_rr_scheduler dut (
    .clk(clk), .reset(reset), .init(init),
    .limit_low_in(limit_low_in), .limit_high_in(limit_high_in),
    .in_empty(in_empty), .in_data(in_data), .out_afull(out_afull),
    .pop(pop), .push(push), .data_out(data_out),
    .limit_low(limit_low), .limit_high(limit_high),
    .state(state), .idle(idle), .xfer_cnt(xfer_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // environment: input FIFO contents
  logic [W-1:0] in_q [N][$];

  task automatic update_inputs();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (in_q[i].size() == 0);
      in_data[i*W +: W] = (in_q[i].size() != 0) ? in_q[i][0] : '0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // reference model: scheduling rules evaluated once per rising edge
  logic [17:0]   exp_q[$];
  bit            started = 0;
  int            m_state;
  int            m_rr;
  logic [N-1:0]  m_mask, m_pop, m_push;
  logic [W-1:0]  m_data;
  logic [LW-1:0] m_low, m_high;
  logic [7:0]    m_cnt;

  always @(posedge clk) begin
    int g, ns;
    logic [W-1:0] w;
    logic [1:0] d;
    if (reset) begin
      started = 1;
      m_state = 0; m_rr = 0; m_mask = '0; m_pop = '0; m_push = '0;
      m_data = '0; m_low = 3'd1; m_high = 3'd6; m_cnt = '0;
      exp_q.delete();
    end else if (started) begin
      g = -1;
      w = '0;
      if (m_state == 3) begin
        for (int k = 0; k < N; k++) begin
          int i;
          logic [W-1:0] cw;
          i = (m_rr + k) % N;
          cw = in_data[i*W +: W];
          if (g < 0 && !in_empty[i] && !out_afull[cw[9:8]] && !m_mask[i]) begin
            g = i;
            w = cw;
          end
        end
      end
      case (m_state)
        0: ns = 1;
        1: ns = init ? 1 : 2;
        2: ns = init ? 1 : ((in_empty != '1) ? 3 : 2);
        default: ns = init ? 1 : ((in_empty == '1 && m_push == '0) ? 2 : 3);
      endcase
      if (m_state == 1 && limit_low_in < limit_high_in) begin
        m_low = limit_low_in;
        m_high = limit_high_in;
      end
      m_state = ns;
      if (g >= 0) begin
        d = w[9:8];
        m_pop = 4'(1) << g;
        m_push = 4'(1) << d;
        m_data = w;
        m_rr = (g + 1) % N;
        m_cnt = m_cnt + 8'd1;
        exp_q.push_back({m_pop, m_push, w});
      end else begin
        m_pop = '0;
        m_push = '0;
      end
      m_mask = m_pop;
    end
  end

  // monitor / scoreboard, then input FIFOs consume popped heads
  always @(negedge clk) begin
    logic [17:0] e;
    if (started) begin
      if (pop != '0 || push != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {14'd0, pop, push}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pop_push_data", {14'd0, pop, push, data_out}, {14'd0, e});
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_strobe", {14'd0, pop, push, data_out}, {14'd0, e});
      end
      chk("state", {30'd0, state}, m_state);
      chk("limit_low", {29'd0, limit_low}, {29'd0, m_low});
      chk("limit_high", {29'd0, limit_high}, {29'd0, m_high});
      chk("idle", {31'd0, idle}, {31'd0, (m_state == 2 && m_push == '0)});
      chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, m_cnt});
    end
    for (int i = 0; i < N; i++)
      if (pop[i] === 1'b1 && in_q[i].size() != 0) void'(in_q[i].pop_front());
    update_inputs();
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic load(input int f, input logic [W-1:0] w);
    in_q[f].push_back(w);
    update_inputs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (in_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_drain(input string name, input int budget, input bit rand_afull);
    int n;
    n = 0;
    while (!(all_empty() && idle === 1'b1 && out_afull == '0)) begin
      if (n >= budget) begin
        fail_now(name);
        out_afull = '0;
        return;
      end
      step(1);
      if (rand_afull && $urandom_range(0, 3) == 0) out_afull = 4'($urandom_range(0, 15));
      else out_afull = '0;
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    step(cycles);
    reset = 1'b0;
    step(3);
  endtask

  task automatic pulse_init(input logic [LW-1:0] lo, input logic [LW-1:0] hi);
    limit_low_in = lo;
    limit_high_in = hi;
    init = 1'b1;
    step(1);
    init = 1'b0;
    step(3);
  endtask

  initial begin
    int n;
    logic [W-1:0] base [N];
    base[0] = 10'h0FF; base[1] = 10'h1EE; base[2] = 10'h2DD; base[3] = 10'h3CC;

    // reset and threshold configuration
    step(1);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_push", {28'd0, push}, 32'd0);
    do_reset(3);
    chk("post_reset_state", {30'd0, state}, 32'd2);
    chk("post_reset_low", {29'd0, limit_low}, 32'd1);
    chk("post_reset_high", {29'd0, limit_high}, 32'd6);
    chk("post_reset_cnt", {24'd0, xfer_cnt}, 32'd0);
    pulse_init(3'd3, 3'd7);
    chk("init_low", {29'd0, limit_low}, 32'd3);
    chk("init_high", {29'd0, limit_high}, 32'd7);
    chk("init_idle", {31'd0, idle}, 32'd1);
    pulse_init(3'd5, 3'd2);
    chk("bad_init_low", {29'd0, limit_low}, 32'd3);
    chk("bad_init_high", {29'd0, limit_high}, 32'd7);

    // round-robin fairness
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) load(i, base[i] - 10'(k));
    wait_drain("rr_drain", 200, 0);
    chk("rr_cnt16", {24'd0, xfer_cnt}, 32'd16);

    // backpressure on output 2
    out_afull = 4'b0100;
    load(0, 10'h2FF);
    load(1, 10'h1EE);
    step(8);
    chk("bp_fifo0_held", in_q[0].size(), 32'd1);
    chk("bp_fifo1_served", in_q[1].size(), 32'd0);
    out_afull = '0;
    wait_drain("bp_drain", 50, 0);

    // single source throughput
    for (int k = 0; k < 4; k++) load(3, {2'($urandom_range(0, 3)), 8'($urandom)});
    step(8);
    chk("single_src_drained", in_q[3].size(), 32'd0);
    wait_drain("single_idle", 20, 0);

    // reset in the grant cycle
    for (int i = 0; i < N; i++) begin
      load(i, {2'($urandom_range(0, 3)), 8'($urandom)});
      load(i, {2'($urandom_range(0, 3)), 8'($urandom)});
    end
    step(1);
    reset = 1'b1;
    step(1);
    chk("mid_reset_pop", {28'd0, pop}, 32'd0);
    chk("mid_reset_push", {28'd0, push}, 32'd0);
    chk("mid_reset_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("mid_reset_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    step(1);
    wait_drain("mid_reset_drain", 200, 0);

    // counter wrap under random backpressure
    do_reset(2);
    for (int k = 0; k < 256; k++)
      load($urandom_range(0, 3), {2'($urandom_range(0, 3)), 8'($urandom)});
    wait_drain("wrap_drain", 4000, 1);
    chk("wrap_cnt", {24'd0, xfer_cnt}, 32'd0);

    // init while active
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) load(i, {2'($urandom_range(0, 3)), 8'($urandom)});
    n = 0;
    while (push == '0 && n < 20) begin
      step(1);
      n++;
    end
    if (n >= 20) fail_now("wait_push");
    limit_low_in = 3'd2;
    limit_high_in = 3'd5;
    init = 1'b1;
    step(2);
    init = 1'b0;
    chk("active_init_state", {30'd0, state}, 32'd1);
    step(1);
    chk("active_init_low", {29'd0, limit_low}, 32'd2);
    wait_drain("active_init_drain", 300, 0);

    // final report
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Central scheduler for the 4-input / 4-output FIFO switch.
- Each cycle it picks at most one non-empty input FIFO in round-robin order and pops its head word.
- It routes the word to the output FIFO selected by bits [9:8], unless that output FIFO reports almost-full.
- It also owns the threshold configuration (limit_low/limit_high) distributed to all FIFOs, latched on init.

Parameters:
- DATA_W, 10, word width; top 2 bits are the destination index.
- N, 4, number of input and output FIFOs (fixed at 4; destination field is 2 bits).
- LIM_W, 3, width of the almost-empty/almost-full threshold fields.
- LOW_RST, 1, limit_low value after reset.
- HIGH_RST, 6, limit_high value after reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  high for ≥1 cycle: latch new thresholds.
- limit_low_in  in  LIM_W  requested almost-empty threshold.
- limit_high_in  in  LIM_W  requested almost-full threshold.
- in_empty  in  N  empty flag of input FIFOs 0..3.
- in_data  in  N*DATA_W  show-ahead head words; FIFO i on bits [i*10+9 : i*10].
- out_afull  in  N  almost-full flag of output FIFOs 4..7 (index 0..3).
- pop  out  N  one-hot pop to input FIFOs.
- push  out  N  one-hot push to output FIFOs.
- data_out  out  DATA_W  word written to the pushed output FIFO.
- limit_low  out  LIM_W  active almost-empty threshold to all FIFOs.
- limit_high  out  LIM_W  active almost-full threshold to all FIFOs.
- state  out  2  0=RESET, 1=INIT, 2=IDLE, 3=ACTIVE.
- idle  out  1  high in IDLE with no transfer in flight.
- xfer_cnt  out  8  total words transferred, wraps 255→0.

Behaviour:
- Reset: when reset=1 at an edge, all outputs take their reset values the next cycle.
  - pop=0, push=0, data_out=0, limit_low=LOW_RST, limit_high=HIGH_RST, xfer_cnt=0, idle=0.
  - state=RESET; round-robin pointer rr=0; mask=0.
  - Reset overrides init and any in-flight transfer. Mid-transfer reset drops the registered pop/push; no partial transfer is counted.
- FSM transitions:
  - RESET→INIT when reset=0.
  - INIT: limit_low/limit_high latch limit_low_in/limit_high_in only if limit_low_in < limit_high_in; otherwise the previous values are held. INIT→IDLE next cycle unless init is still 1 (then it stays in INIT).
  - IDLE→ACTIVE when any in_empty bit is 0.
  - ACTIVE→IDLE when all in_empty=1 and no pop/push is pending.
  - init=1 from IDLE or ACTIVE→INIT. From ACTIVE, a transfer already granted still completes; no new grants are made in INIT.
- Eligibility: requester i is eligible in cycle N when all of the following hold:
  - state=ACTIVE;
  - in_empty[i]=0;
  - out_afull[in_data_i[9:8]]=0;
  - mask[i]=0.
- Grant: the first eligible index searching rr, rr+1, … modulo 4. On grant g, rr←(g+1) mod 4. With no eligible requester, rr holds.
- Latency:
  - A grant in cycle N registers pop[g]=1, push[dest]=1 and data_out=in_data_g at the N+1 edge; both strobes stay high exactly one cycle.
  - mask[g] is set for cycle N+1 only, because in_empty/in_data are stale until the pop takes effect. Result: one requester can be granted at most every other cycle, while the switch as a whole can transfer one word per cycle.
- xfer_cnt increments by 1 on each push cycle, modulo 256.
- Backpressure: out_afull is sampled at grant time. limit_high must leave ≥1 slot of margin; no words are dropped provided the output FIFO honours that margin.
- Simultaneous events: several inputs targeting the same destination are served strictly round-robin; blocked requesters do not advance rr.
- idle=1 iff state=IDLE and push=0.

Test Plan:
1. Reset/config: reset=1 for 3 cycles, then init=1 with limit_low_in=3, limit_high_in=7 → limit_low=3, limit_high=7 two cycles after init, state=IDLE, idle=1. Repeat with limit_low_in=5, limit_high_in=2 → thresholds stay 3/7.
2. Round-robin fairness: preload 4 words each in FIFOs 0..3 (data 0x0FF, 0x1EE, 0x2DD, 0x3CC pattern, k=0..3) → grant order 0,1,2,3 repeating; 16 pushes; xfer_cnt=16; each data_out lands on push[word[9:8]].
3. Backpressure: hold out_afull[2]=1 with FIFO 0 head=0x2FF and FIFO 1 head=0x1EE → only FIFO 1 is served; FIFO 0 is served in the cycle after out_afull[2] drops.
4. Single-source throughput: only FIFO 3 non-empty, with 4 words → pop[3] asserted on alternate cycles (mask), 4 pushes within 8 cycles, then ACTIVE→IDLE.
5. Reset mid-operation: assert reset the cycle after a grant → no pop/push pulse, xfer_cnt=0, state=RESET.
6. Counter wrap: 256 transfers → xfer_cnt returns to 0; init during ACTIVE → in-flight push completes and no further grants occur until IDLE→ACTIVE.
